serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/fullAdder.sv | 13 +
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and
// the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fullAdder.sv
// One-bit full adder cell shared across the codebase.
module fullAdder (
  output logic sum,
  output logic carry,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes op_a - op_b one bit per cycle,
// LSB first, as op_a + ~op_b + 1 through a single full adder.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             serial_bit
);

  // One extra bit so the post-increment on the last bit never wraps.
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             borrow_q;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  fullAdder u_fa (
    .sum   (fa_sum),
    .carry (fa_carry),
    .a     (a_q[0]),
    .b     (~b_q[0]),
    .cin   (carry_q)
  );

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the default assignment up front keeps this block free of latches
  // on any path the case statement does not cover.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == DONE);
    serial_bit = (state_q == SHIFT) ? fa_sum : 1'b0;
  end

  // Operands shift right so the adder always sees the bit under process at
  // position 0; results land in place at diff[cnt].
  // NOTE: every datapath register, including the result, is reset so the
  // visible outputs are defined immediately after reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b1;
      borrow_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_carry;
          cnt_q   <= cnt_q + CNT_W'(1);
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) diff_q[i] <= fa_sum;
          end
          // Final carry-out of a + ~b + 1 is the inverted borrow.
          if (last_bit) borrow_q <= ~fa_carry;
        end
        default: ;
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: a cycle model predicts busy,
// done and serial bits; results are scoreboarded through a queue.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  typedef struct packed {
    logic             borrow;
    logic [WIDTH-1:0] diff;
  } result_t;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             serial_bit;

  int      n_checks = 0;
  int      n_errors = 0;
  result_t sb_q[$];
  int      m_left = 0;
  result_t m_cur = '0;
  result_t m_last = '0;
  int      n_done = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow     (borrow),
    .serial_bit (serial_bit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic result_t model_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    result_t r;
    r.diff   = a - b;
    r.borrow = (a < b);
    return r;
  endfunction

  // Reference model updates on the rising edge; the monitor compares on the
  // falling edge. Kept in one process so model state has a single writer.
  initial begin
    result_t got_exp;
    forever begin
      @(posedge clk or negedge clk or negedge reset_n);
      if (!reset_n) begin
        m_left = 0;
        m_last = '0;
        sb_q.delete();
      end else if (clk) begin
        if (m_left == 0) begin
          if (start) begin
            m_cur = model_sub(op_a, op_b);
            sb_q.push_back(m_cur);
            m_left = WIDTH + 1;
          end
        end else begin
          m_left--;
        end
      end else begin
        check("busy", busy, m_left != 0);
        check("done", done, m_left == 1);
        if (m_left >= 2) begin
          check("serial_bit", serial_bit, m_cur.diff[WIDTH + 1 - m_left]);
        end else if (m_left == 1) begin
          n_done++;
          check("sb_nonempty", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            got_exp = sb_q.pop_front();
            check("diff", diff, got_exp.diff);
            check("borrow", borrow, got_exp.borrow);
            m_last = got_exp;
          end
        end else begin
          check("hold_diff", diff, m_last.diff);
          check("hold_borrow", borrow, m_last.borrow);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    step(1);
    start = 1'b0;
    op_a  = WIDTH'($urandom);
    op_b  = WIDTH'($urandom);
    step(WIDTH + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_diff"}, diff, 0);
    check({tag, "_borrow"}, borrow, 0);
    check({tag, "_serial"}, serial_bit, 0);
  endtask

  initial begin
    int done_before;
    #3;
    check_reset_outputs("por");

    // Start is already high when reset releases: the first edge accepts it.
    start = 1'b1;
    op_a  = 4'd7;
    op_b  = 4'd3;
    #9;
    reset_n = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    // Second start two edges later must be ignored.
    start = 1'b1;
    op_a  = 4'd1;
    op_b  = 4'd1;
    step(1);
    start = 1'b0;
    step(WIDTH);
    check("first_done_count", n_done, 1);
    step(2);

    run_op(4'd3, 4'd4);
    run_op(4'd0, 4'd0);
    run_op(4'd15, 4'd15);

    // Reset mid-operation aborts without a done pulse.
    done_before = n_done;
    start = 1'b1;
    op_a  = 4'd7;
    op_b  = 4'd3;
    step(1);
    start = 1'b0;
    step(2);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    #3;
    reset_n = 1'b1;
    step(WIDTH + 3);
    check("abort_no_done", n_done, done_before);
    run_op(4'd9, 4'd2);

    // Continuous start: one result every WIDTH+2 cycles.
    done_before = n_done;
    start = 1'b1;
    op_a  = 4'd5;
    op_b  = 4'd6;
    step(20);
    start = 1'b0;
    step(WIDTH + 2);
    check("burst_done_count", n_done - done_before, 4);

    for (int i = 0; i < 8; i++) begin
      run_op(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)));
    end
    step(2);

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
